// File: rtl/sr_latch_arbiter.sv
// Round-robin controller sharing one bank of SR latches between requesters; s/r are never high together.
// Optional read-back check of the latch outputs enabled by defining SR_READBACK_EN.
module sr_latch_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3,
  parameter int HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        op,
  input  logic [NREQ*IDXW-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic [NFLAG-1:0]       s,
  output logic [NFLAG-1:0]       r,
  input  logic [NFLAG-1:0]       q,
  output logic                   err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned NF = NFLAG;
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t            state_q, state_n;
  logic [PW-1:0]     ptr_q, ptr_n, win_q, win_n, win_sel, cand;
  logic              op_q, op_n, found;
  logic [IDXW-1:0]   idx_q, idx_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [NFLAG-1:0]  s_n, r_n, sel_flag;
  logic [NREQ-1:0]   gnt_n;
  logic              busy_n, err_n;
  logic [IDXW-1:0]   idx_arr [NREQ];

  // Out-of-range indices decode to all zeros, so they never reach the bank.
  function automatic logic [NFLAG-1:0] decode(input logic [IDXW-1:0] i);
    logic [NFLAG-1:0] d;
    d = '0;
    for (int unsigned f = 0; f < NF; f++)
      if (32'(i) == f) d[f] = 1'b1;
    return d;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NR; i++)
      idx_arr[i] = idx[i*IDXW +: IDXW];
  end

  // Search upward from the pointer, wrapping; first hit wins.
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      cand = PW'((32'(ptr_q) + i) % NR);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_sel = cand;
      end
    end
  end

  assign sel_flag = decode(idx_q);

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    win_n   = win_q;
    op_n    = op_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    s_n     = '0;
    r_n     = '0;
    gnt_n   = '0;
    err_n   = err;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_n = DRIVE;
          win_n   = win_sel;
          op_n    = op[win_sel];
          idx_n   = idx_arr[win_sel];
          cnt_n   = CW'(HOLD - 1);
          s_n     = op_n ? decode(idx_n) : '0;
          r_n     = op_n ? '0 : decode(idx_n);
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_n      = GAP;
          gnt_n[win_q] = 1'b1;
        end else begin
          cnt_n = cnt_q - CW'(1);
          s_n   = op_q ? sel_flag : '0;
          r_n   = op_q ? '0 : sel_flag;
        end
      end
      GAP: begin
        state_n = IDLE;
        ptr_n   = PW'((32'(win_q) + 32'd1) % NR);
`ifdef SR_READBACK_EN
        if ((|sel_flag) && ((|(q & sel_flag)) != op_q)) err_n = 1'b1;
`endif
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

`ifndef SR_READBACK_EN
  logic unused_q;
  assign unused_q = ^q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      s       <= '0;
      r       <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      win_q   <= win_n;
      op_q    <= op_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      s       <= s_n;
      r       <= r_n;
      gnt     <= gnt_n;
      busy    <= busy_n;
      err     <= err_n;
    end
  end

endmodule
